// File: rtl/snake_step_ctrl.sv
// Game-step sequencer for the snake world memory: moves the head, clears the tail or places food.
// Optional WRAP_EN: heads leaving the grid wrap to the opposite edge instead of ending the game.
module snake_step_ctrl #(
    parameter int         GRID      = 15,
    parameter int         MAX_LEN   = 64,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir_in,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [4:0] wr_x,
    output logic [4:0] wr_y,
    output logic [1:0] wr_data,
    output logic       busy,
    output logic       step_done,
    output logic       game_over,
    output logic [7:0] score,
    output logic [6:0] length
);

    localparam int         PW        = $clog2(MAX_LEN);
    localparam logic [4:0] GRID_C    = 5'(GRID);
    localparam logic [6:0] MAX_LEN_C = 7'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CALC = 4'd1,
        S_RD   = 4'd2,
        S_CHK  = 4'd3,
        S_WH   = 4'd4,
        S_WT   = 4'd5,
        S_FRD  = 4'd6,
        S_FCHK = 4'd7,
        S_DONE = 4'd8,
        S_OVER = 4'd9
    } state_t;

    state_t        state_q;
    logic [1:0]    dir_q;
    logic [1:0]    pend_q;
    logic [7:0]    lfsr_q;
    logic [7:0]    lfsr_d;
    logic [4:0]    body_x_q [MAX_LEN];
    logic [4:0]    body_y_q [MAX_LEN];
    logic [PW-1:0] head_ptr_q;
    logic [PW-1:0] tail_ptr_q;
    logic [6:0]    len_q;
    logic [7:0]    score_q;
    logic          grow_q;
    logic          game_over_q;
    logic          step_done_q;
    logic          wr_en_q;
    logic [4:0]    wr_x_q;
    logic [4:0]    wr_y_q;
    logic [1:0]    wr_data_q;
    logic [4:0]    rd_x_q;
    logic [4:0]    rd_y_q;
    logic [4:0]    nh_x_q;
    logic [4:0]    nh_y_q;
    logic [4:0]    cand_x_q;
    logic [4:0]    cand_y_q;

    logic [4:0]    nh_x_s;
    logic [4:0]    nh_y_s;
    logic          nh_out_s;
    logic [4:0]    cand_x_s;
    logic [4:0]    cand_y_s;
    logic [1:0]    ref_dir_s;
    logic          food_wr_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_LEN - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Fibonacci LFSR successor, taps 8,6,5,4.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Food candidate derived from the current LFSR value.
    always_comb begin
        cand_x_s = ({1'b0, lfsr_q[3:0]} % GRID_C) + 5'd1;
        cand_y_s = ({1'b0, lfsr_q[7:4]} % GRID_C) + 5'd1;
    end

    // Reversal check is against the direction about to be committed while in CALC.
    always_comb begin
        if (state_q == S_CALC) begin
            ref_dir_s = pend_q;
        end else begin
            ref_dir_s = dir_q;
        end
    end

    // Next head position from the pending direction.
    always_comb begin
        nh_x_s = body_x_q[head_ptr_q];
        nh_y_s = body_y_q[head_ptr_q];
        case (pend_q)
            2'b00:   nh_y_s = nh_y_s - 5'd1;
            2'b01:   nh_x_s = nh_x_s + 5'd1;
            2'b10:   nh_y_s = nh_y_s + 5'd1;
            2'b11:   nh_x_s = nh_x_s - 5'd1;
            default: nh_x_s = nh_x_s;
        endcase
        nh_out_s = (nh_x_s == 5'd0) || (nh_x_s > GRID_C) ||
                   (nh_y_s == 5'd0) || (nh_y_s > GRID_C);
`ifdef WRAP_EN
        if (nh_x_s == 5'd0) begin
            nh_x_s = GRID_C;
        end else if (nh_x_s > GRID_C) begin
            nh_x_s = 5'd1;
        end else begin
            nh_x_s = nh_x_s;
        end
        if (nh_y_s == 5'd0) begin
            nh_y_s = GRID_C;
        end else if (nh_y_s > GRID_C) begin
            nh_y_s = 5'd1;
        end else begin
            nh_y_s = nh_y_s;
        end
        nh_out_s = 1'b0;
`endif
    end

    // The food write must land in the same cycle rd_data returns, so it bypasses the output flops.
    assign food_wr_s = (state_q == S_FCHK) && (rd_data == 2'b00);
    assign wr_en     = (wr_en_q || food_wr_s) && !rst;
    assign wr_x      = food_wr_s ? cand_x_q : wr_x_q;
    assign wr_y      = food_wr_s ? cand_y_q : wr_y_q;
    assign wr_data   = food_wr_s ? 2'b01 : wr_data_q;
    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_OVER);
    assign step_done = step_done_q;
    assign game_over = game_over_q;
    assign score     = score_q;
    assign length    = len_q;

    // Step sequencer, body buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dir_q       <= 2'b01;
            pend_q      <= 2'b01;
            lfsr_q      <= LFSR_SEED;
            body_x_q[0] <= 5'd1;
            body_y_q[0] <= 5'd1;
            body_x_q[1] <= 5'd2;
            body_y_q[1] <= 5'd1;
            body_x_q[2] <= 5'd3;
            body_y_q[2] <= 5'd1;
            head_ptr_q  <= PW'(2);
            tail_ptr_q  <= {PW{1'b0}};
            len_q       <= 7'd3;
            score_q     <= 8'd0;
            grow_q      <= 1'b0;
            game_over_q <= 1'b0;
            step_done_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_x_q      <= 5'd0;
            wr_y_q      <= 5'd0;
            wr_data_q   <= 2'b00;
            rd_x_q      <= 5'd0;
            rd_y_q      <= 5'd0;
            nh_x_q      <= 5'd0;
            nh_y_q      <= 5'd0;
            cand_x_q    <= 5'd0;
            cand_y_q    <= 5'd0;
        end else begin
            lfsr_q      <= lfsr_d;
            wr_en_q     <= 1'b0;
            step_done_q <= 1'b0;
            if (dir_valid && (dir_in != (ref_dir_s ^ 2'b10))) begin
                pend_q <= dir_in;
            end
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    dir_q  <= pend_q;
                    nh_x_q <= nh_x_s;
                    nh_y_q <= nh_y_s;
                    if (nh_out_s) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q <= S_RD;
                        rd_x_q  <= nh_x_s;
                        rd_y_q  <= nh_y_s;
                    end
                end
                S_RD: begin
                    state_q <= S_CHK;
                end
                S_CHK: begin
                    if (rd_data == 2'b10) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        grow_q    <= (rd_data == 2'b01);
                        state_q   <= S_WH;
                        wr_en_q   <= 1'b1;
                        wr_x_q    <= nh_x_q;
                        wr_y_q    <= nh_y_q;
                        wr_data_q <= 2'b10;
                    end
                end
                S_WH: begin
                    // Tail coordinates are captured before the push, which may reuse the tail slot when full.
                    head_ptr_q                    <= ptr_inc(head_ptr_q);
                    body_x_q[ptr_inc(head_ptr_q)] <= nh_x_q;
                    body_y_q[ptr_inc(head_ptr_q)] <= nh_y_q;
                    wr_en_q                       <= !grow_q || (len_q == MAX_LEN_C);
                    wr_x_q                        <= body_x_q[tail_ptr_q];
                    wr_y_q                        <= body_y_q[tail_ptr_q];
                    wr_data_q                     <= 2'b00;
                    state_q                       <= S_WT;
                end
                S_WT: begin
                    if (!grow_q) begin
                        tail_ptr_q  <= ptr_inc(tail_ptr_q);
                        step_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        if (score_q != 8'd255) begin
                            score_q <= score_q + 8'd1;
                        end
                        if (len_q < MAX_LEN_C) begin
                            len_q <= len_q + 7'd1;
                        end else begin
                            tail_ptr_q <= ptr_inc(tail_ptr_q);
                        end
                        cand_x_q <= cand_x_s;
                        cand_y_q <= cand_y_s;
                        rd_x_q   <= cand_x_s;
                        rd_y_q   <= cand_y_s;
                        state_q  <= S_FRD;
                    end
                end
                S_FRD: begin
                    state_q <= S_FCHK;
                end
                S_FCHK: begin
                    if (rd_data == 2'b00) begin
                        step_done_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cand_x_q <= cand_x_s;
                        cand_y_q <= cand_y_s;
                        rd_x_q   <= cand_x_s;
                        rd_y_q   <= cand_y_s;
                        state_q  <= S_FRD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scoreboard bench for snake_step_ctrl: an independent snake/LFSR model predicts every write and output.
module tb_snake_step_ctrl;

    localparam int         GRID    = 15;
    localparam int         MAX_LEN = 64;
    localparam logic [7:0] SEED    = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [1:0] rd_data = 2'b00;
    logic [4:0] rd_x, rd_y, wr_x, wr_y;
    logic       wr_en, busy, step_done, game_over;
    logic [1:0] wr_data;
    logic [7:0] score;
    logic [6:0] length;

    int total = 0;
    int bad   = 0;

    logic [11:0] sb[$];
    int          bx[$];
    int          by[$];
    logic [1:0]  dir_m, pend_m;
    int          len_m, score_m;
    bit          over_m;
    logic [7:0]  lfsr_m, lfsr_used;

    always #5 clk = ~clk;

    snake_step_ctrl #(.GRID(GRID), .MAX_LEN(MAX_LEN), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .tick(tick), .dir_valid(dir_valid), .dir_in(dir_in),
        .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .busy(busy), .step_done(step_done), .game_over(game_over),
        .score(score), .length(length)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR; lfsr_used is the value the DUT held just before the latest edge.
    always @(posedge clk) begin
        lfsr_used <= lfsr_m;
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    // Every write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                check_val("wr_cell", 32'({wr_x, wr_y, wr_data}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [9:0] cand(input logic [7:0] l);
        int x, y;
        x = (int'(l[3:0]) % GRID) + 1;
        y = (int'(l[7:4]) % GRID) + 1;
        return {5'(x), 5'(y)};
    endfunction

    task automatic model_reset();
        bx = '{1, 2, 3};
        by = '{1, 1, 1};
        dir_m = 2'b01; pend_m = 2'b01;
        len_m = 3; score_m = 0; over_m = 1'b0;
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        check_val("rst_length", 32'(length), 32'd3);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_over", 32'(game_over), 32'd0);
        check_val("rst_done", 32'(step_done), 32'd0);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_rd", 32'({rd_x, rd_y}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; dir_valid = 1'b0; rd_data = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_reset_vals();
    endtask

    task automatic set_dir(input logic [1:0] d);
        @(posedge clk);
        #1 dir_valid = 1'b1; dir_in = d;
        @(posedge clk);
        #1 dir_valid = 1'b0;
        if (d != (dir_m ^ 2'b10)) pend_m = d;
    endtask

    task automatic start_tick();
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    // One game step; retries = number of occupied food candidates before an empty one.
    task automatic do_step(input logic [1:0] chk_val, input int retries);
        int nx, ny, done_c, food_c, over_c, last, k;
        bit out, collide, normal, grow, tclear, exp_we;
        logic [9:0] ec;
        nx = bx[bx.size() - 1];
        ny = by[by.size() - 1];
        dir_m = pend_m;
        case (dir_m)
            2'b00:   ny = ny - 1;
            2'b01:   nx = nx + 1;
            2'b10:   ny = ny + 1;
            default: nx = nx - 1;
        endcase
        out = (nx < 1) || (nx > GRID) || (ny < 1) || (ny > GRID);
`ifdef WRAP_EN
        if (nx < 1) nx = GRID;
        if (nx > GRID) nx = 1;
        if (ny < 1) ny = GRID;
        if (ny > GRID) ny = 1;
        out = 1'b0;
`endif
        collide = !out && (chk_val == 2'b10);
        normal  = !out && !collide;
        grow    = normal && (chk_val == 2'b01);
        tclear  = normal && (!grow || len_m == MAX_LEN);
        if (normal) sb.push_back({5'(nx), 5'(ny), 2'b10});
        if (tclear) sb.push_back({5'(bx[0]), 5'(by[0]), 2'b00});
        food_c = 7 + 2 * retries;
        done_c = grow ? food_c + 1 : 6;
        over_c = out ? 2 : 4;
        last   = normal ? done_c + 1 : 6;
        rd_data = chk_val;
        start_tick();
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_we = normal && (c == 4 || (c == 5 && tclear) || (grow && c == food_c));
            check_val("wr_en", 32'(wr_en), 32'(exp_we));
            check_val("step_done", 32'(step_done), 32'(normal && c == done_c));
            if (c == 1) check_val("busy_calc", 32'(busy), 32'd1);
            if (c == 2 && !out) check_val("rd_head", 32'({rd_x, rd_y}), 32'({5'(nx), 5'(ny)}));
            if (grow && c >= 6 && c < food_c && ((c - 6) % 2 == 0)) begin
                k  = (c - 6) / 2;
                ec = cand(lfsr_used);
                check_val("rd_food", 32'({rd_x, rd_y}), 32'(ec));
                rd_data = (k < retries) ? 2'b10 : 2'b00;
                if (k == retries) sb.push_back({ec, 2'b01});
            end
            if (!normal && c >= over_c) check_val("game_over", 32'(game_over), 32'd1);
            if (c == 2) tick = 1'b1;
            if (c == 3) tick = 1'b0;
        end
        if (normal) begin
            bx.push_back(nx);
            by.push_back(ny);
            if (tclear) begin
                void'(bx.pop_front());
                void'(by.pop_front());
            end
            if (grow && score_m < 255) score_m++;
            if (grow && len_m < MAX_LEN) len_m++;
        end else begin
            over_m = 1'b1;
        end
        check_val("length", 32'(length), 32'(len_m));
        check_val("score", 32'(score), 32'(score_m));
        check_val("busy_end", 32'(busy), 32'd0);
        check_val("over_flag", 32'(game_over), 32'(over_m));
    endtask

    task automatic tick_after_over();
        start_tick();
        repeat (8) begin
            @(negedge clk);
            check_val("over_done", 32'(step_done), 32'd0);
            check_val("over_busy", 32'(busy), 32'd0);
            check_val("over_hold", 32'(game_over), 32'd1);
        end
    endtask

    initial begin
        do_reset();
        do_step(2'b00, 0);                       // head to (4,1)
        set_dir(2'b11);                          // reverse request, dropped
        do_step(2'b00, 0);                       // (5,1)
        set_dir(2'b10);
        for (int i = 0; i < 3; i++) do_step(2'b00, 0);   // down to (5,4)
        set_dir(2'b01);
        for (int i = 0; i < 5; i++) do_step(2'b00, 0);   // right to (10,4)
        do_step(2'b01, 0);                       // eat at (11,4)
        do_step(2'b01, 2);                       // eat with two food retries
        do_step(2'b00, 0);
        do_step(2'b10, 0);                       // body collision
        tick_after_over();

        do_reset();
        for (int i = 0; i < 12; i++) do_step(2'b00, 0);  // to (15,1)
        do_step(2'b00, 0);                       // wall exit
        if (over_m) tick_after_over();

        do_reset();
        start_tick();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_wr_en", 32'(wr_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_reset_vals();
        do_step(2'b00, 0);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
